// File: rtl/z16_instr_ram.sv
// Z16 instruction RAM: DEPTH x 16-bit, byte-addressed fetch port plus word-indexed program-load port.
// Latency: fetch registered, response one cycle after i_req is sampled in RUN; BOOT takes DEPTH cycles.
// Backpressure: none; fetches accepted every cycle in RUN, dropped in BOOT (o_ready low). Macro Z16_IMEM_BOOTROM_EN selects boot program.
module z16_instr_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 16,
    parameter int WW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [15:0]   o_instr,
    output logic          o_valid,
    output logic          o_fault,
    output logic          o_ready,
    input  logic          i_wr_en,
    input  logic [WW-1:0] i_wr_addr,
    input  logic [15:0]   i_wr_data
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] cnt;
    logic [15:0]   boot_dat;
    logic [15:0]   mem [DEPTH];
    logic [WW-1:0] fetch_idx;
    logic          fetch_fault;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == BOOT)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == BOOT && cnt == WW'(DEPTH - 1))
            state_nxt = RUN;
    end

`ifdef Z16_IMEM_BOOTROM_EN
    always_comb begin
        boot_dat = 16'h0000;
        case (cnt)
            WW'(0):  boot_dat = 16'h0010;
            WW'(1):  boot_dat = 16'h0020;
            WW'(2):  boot_dat = 16'h0519;
            WW'(3):  boot_dat = 16'h1220;
            WW'(4):  boot_dat = 16'hFF19;
            WW'(5):  boot_dat = 16'hFC4F;
            WW'(6):  boot_dat = 16'h0040;
            WW'(7):  boot_dat = 16'h7A49;
            WW'(8):  boot_dat = 16'h240B;
            WW'(9):  boot_dat = 16'h00FD;
            default: boot_dat = 16'h0000;
        endcase
    end
`else
    always_comb boot_dat = 16'h0000;
`endif

    // Memory has no reset: contents come only from the BOOT sweep or the load port.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (state == BOOT)
                mem[cnt] <= boot_dat;
            else if (i_wr_en)
                mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign fetch_idx   = i_addr[WW:1];
    // Any address bit above the word index faults rather than wrapping.
    assign fetch_fault = i_addr[0] | ((i_addr >> (WW + 1)) != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_fault <= 1'b0;
            o_instr <= 16'h0000;
        end else if (state == RUN && i_req) begin
            o_valid <= 1'b1;
            o_fault <= fetch_fault;
            o_instr <= fetch_fault ? 16'h0000 : mem[fetch_idx];
        end else begin
            o_valid <= 1'b0;
        end
    end

    assign o_ready = (state == RUN);

endmodule

// File: doc/z16_instr_ram.md
Z16_INSTR_RAM -- requirements
Module: z16_instr_ram

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the instruction word count; a power of two, 16..32768.
REQ-002 Parameter AW, default 16, SHALL set the byte-address width of i_addr.
REQ-003 Parameter WW, derived as log2(DEPTH), SHALL set the word-index width of i_wr_addr.
REQ-004 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 i_rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 i_req  input  1  SHALL be the fetch request, sampled each cycle.
REQ-007 i_addr  input  AW  SHALL be the fetch byte address; bit 0 is the alignment bit, bits [WW:1] are the word index.
REQ-008 o_instr  output  16  SHALL be the registered instruction word.
REQ-009 o_valid  output  1  SHALL indicate that o_instr holds a response to a fetch.
REQ-010 o_fault  output  1  SHALL flag a misaligned or out-of-range fetch, qualified by o_valid.
REQ-011 o_ready  output  1  SHALL be high only in state RUN.
REQ-012 i_wr_en, i_wr_addr (WW), i_wr_data (16)  input  SHALL form the program-load write port.

Function
REQ-013 The block SHALL implement exactly two states: BOOT and RUN.
REQ-014 BOOT SHALL write one word per cycle at index 0..DEPTH-1 from a counter, taking DEPTH cycles; the transition to RUN SHALL follow the cycle that writes index DEPTH-1.
REQ-015 Fetch latency SHALL be 1 cycle: i_req high in RUN at edge N gives o_valid=1 after edge N+1; i_req low gives o_valid=0.
REQ-016 Fetches SHALL be accepted every cycle with no stall; back-to-back requests SHALL give back-to-back responses.
REQ-017 An i_req in BOOT SHALL be dropped: no response, o_valid stays 0.
REQ-018 A fetch with i_addr[0]=1 SHALL return o_instr=0x0000 with o_fault=1.
REQ-019 A fetch with any i_addr bit above bit WW set SHALL return o_instr=0x0000 with o_fault=1; the index SHALL never wrap.
REQ-020 A valid fetch SHALL return the stored word with o_fault=0.
REQ-021 i_wr_en in RUN SHALL write i_wr_data at i_wr_addr at the edge.
REQ-022 i_wr_en in BOOT SHALL be ignored.
REQ-023 A fetch and a write to the same index in the same cycle SHALL return the old word (read-first); the new word SHALL be visible from the next fetch.
REQ-024 o_instr and o_fault SHALL hold their last value while o_valid=0.

Reset
REQ-025 While i_rst_n=0 at an edge, the block SHALL enter BOOT with counter=0, o_valid=0, o_fault=0, o_instr=0x0000, o_ready=0.
REQ-026 A reset asserted mid-BOOT or mid-RUN SHALL restart BOOT from index 0 and discard any response in flight.
REQ-027 Memory contents SHALL be defined only by BOOT; reset itself SHALL not clear memory.

Configuration
REQ-028 With macro Z16_IMEM_BOOTROM_EN defined, BOOT SHALL write a built-in program at indices 0..9 (0x0010, 0x0020, 0x0519, 0x1220, 0xFF19, 0xFC4F, 0x0040, 0x7A49, 0x240B, 0x00FD) and 0x0000 at all other indices.
REQ-029 Without Z16_IMEM_BOOTROM_EN, BOOT SHALL write 0x0000 at every index; BOOT duration SHALL be DEPTH cycles in both builds.

Verification
REQ-030 Release reset with DEPTH=256 -> o_ready=0 for 256 cycles, then 1; i_req during BOOT -> o_valid stays 0.
REQ-031 With Z16_IMEM_BOOTROM_EN, fetch i_addr=0x0006 then 0x0012 on consecutive cycles -> o_instr=0x1220 then 0x00FD, o_valid=1 on both, o_fault=0; without the macro -> 0x0000 on both.
REQ-032 Fetch i_addr=0x0003 -> o_instr=0x0000, o_fault=1; fetch i_addr=0x0200 with DEPTH=256 -> o_instr=0x0000, o_fault=1.
REQ-033 In RUN, write 0xABCD to index 5 while fetching i_addr=0x000A in the same cycle -> old word returned; next fetch of 0x000A -> 0xABCD.
REQ-034 Assert i_rst_n=0 for one cycle at boot count 100, then release -> full 256-cycle BOOT restarts; an earlier write at index 5 is overwritten by the boot value.
REQ-035 i_wr_en pulsed during BOOT with 0x1111 at index 3 -> after RUN, fetch 0x0006 returns the boot value, not 0x1111.
